// File: rtl/fp_mul_scheduler_if.sv
// ---------------------------------------------------------------------------
// fp_mul_scheduler_if
//   Bundles the three handshakes of the floating-point multiply scheduler:
//     - operand intake : in_valid / in_ready / op_a / op_b
//     - multiplier leg : mul_start / mul_a / mul_b / mul_done / mul_result
//     - result output  : out_valid / out_ready / out_result / out_special /
//                        out_invalid
//   Modports:
//     slave  - the scheduler's view (drives in_ready, mul_*, out_*)
//     master - the surrounding environment's view (drives the rest)
//   Operand layout is [sign][exponent][mantissa], W = EXP_WIDTH+MANT_WIDTH+1.
// ---------------------------------------------------------------------------
interface fp_mul_scheduler_if #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23
);
  localparam int W = EXP_WIDTH + MANT_WIDTH + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;

  logic         mul_start;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic         mul_done;
  logic [W-1:0] mul_result;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_special;
  logic         out_invalid;

  modport slave (
    input  in_valid, op_a, op_b, mul_done, mul_result, out_ready,
    output in_ready, mul_start, mul_a, mul_b,
           out_valid, out_result, out_special, out_invalid
  );

  modport master (
    output in_valid, op_a, op_b, mul_done, mul_result, out_ready,
    input  in_ready, mul_start, mul_a, mul_b,
           out_valid, out_result, out_special, out_invalid
  );
endinterface

// File: rtl/fp_mul_scheduler.sv
// ---------------------------------------------------------------------------
// fp_mul_scheduler
//   Accepts one IEEE-style operand pair at a time, resolves special cases
//   (NaN, infinity, zero) locally, and hands ordinary pairs to an external
//   multiplier, guarding that wait with a cycle timeout.
//   Ports:
//     clk          - single rising-edge clock
//     rst          - synchronous active-high reset
//     bus (slave)  - operand intake, multiplier leg, result output
//   Optional feature (macro FP_MUL_SCHED_FLAGS_EN):
//     flags_clr    in  - clears the sticky flags (wins over a same-cycle set)
//     flag_invalid out - sticky: a delivered result had out_invalid=1
//     flag_nan     out - sticky: a delivered result came from a NaN operand
// ---------------------------------------------------------------------------
module fp_mul_scheduler #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23,
  parameter int TIMEOUT    = 64
) (
  input  logic clk,
  input  logic rst,
`ifdef FP_MUL_SCHED_FLAGS_EN
  input  logic flags_clr,
  output logic flag_invalid,
  output logic flag_nan,
`endif
  fp_mul_scheduler_if.slave bus
);
  localparam int W  = EXP_WIDTH + MANT_WIDTH + 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

  logic [1:0]    r_state;
  logic [W-1:0]  r_mul_a;
  logic [W-1:0]  r_mul_b;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_out_result;
  logic          r_out_special;
  logic          r_out_invalid;

  // Per-operand classification of the captured pair.
  logic [W-1:0] w_op [2];
  logic [1:0]   w_zero;
  logic [1:0]   w_inf;
  logic [1:0]   w_nan;

  assign w_op[0] = r_mul_a;
  assign w_op[1] = r_mul_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_class
      logic w_exp_zero;
      logic w_exp_ones;
      logic w_mant_zero;
      assign w_exp_zero  = ~|w_op[gi][W-2 -: EXP_WIDTH];
      assign w_exp_ones  =  &w_op[gi][W-2 -: EXP_WIDTH];
      assign w_mant_zero = ~|w_op[gi][MANT_WIDTH-1:0];
      assign w_zero[gi]  = w_exp_zero & w_mant_zero;
      assign w_inf[gi]   = w_exp_ones & w_mant_zero;
      assign w_nan[gi]   = w_exp_ones & ~w_mant_zero;
    end
  endgenerate

  logic         w_sign_x;
  logic         w_special;
  logic         w_spec_invalid;
  logic [W-1:0] w_spec_result;

  assign w_sign_x = r_mul_a[W-1] ^ r_mul_b[W-1];

  // Special-case resolution in priority order: NaN, inf*0, inf, zero.
  always_comb begin
    w_special      = 1'b1;
    w_spec_invalid = 1'b0;
    w_spec_result  = '0;
    if (|w_nan) begin
      w_spec_result = QNAN;
    end else if ((w_inf[0] & w_zero[1]) | (w_inf[1] & w_zero[0])) begin
      w_spec_result  = QNAN;
      w_spec_invalid = 1'b1;
    end else if (|w_inf) begin
      w_spec_result = {w_sign_x, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    end else if (|w_zero) begin
      w_spec_result = {w_sign_x, {(W-1){1'b0}}};
    end else begin
      w_special = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_cnt         <= '0;
      r_out_result  <= '0;
      r_out_special <= 1'b0;
      r_out_invalid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_mul_a <= bus.op_a;
            r_mul_b <= bus.op_b;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_special) begin
            r_out_result  <= w_spec_result;
            r_out_special <= 1'b1;
            r_out_invalid <= w_spec_invalid;
            r_state       <= ST_RESP;
          end else begin
            r_cnt         <= '0;
            r_out_special <= 1'b0;
            r_state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A completion arriving on the final counted cycle beats the timeout.
          if (bus.mul_done) begin
            r_out_result  <= bus.mul_result;
            r_out_invalid <= 1'b0;
            r_state       <= ST_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_out_result  <= QNAN;
            r_out_invalid <= 1'b1;
            r_state       <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_RESP: begin
          if (bus.out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == ST_IDLE);
  assign bus.mul_start   = (r_state == ST_CHECK) & ~w_special;
  assign bus.mul_a       = r_mul_a;
  assign bus.mul_b       = r_mul_b;
  assign bus.out_valid   = (r_state == ST_RESP);
  assign bus.out_result  = r_out_result;
  assign bus.out_special = r_out_special;
  assign bus.out_invalid = r_out_invalid;

`ifdef FP_MUL_SCHED_FLAGS_EN
  logic r_nan_res;
  logic r_flag_invalid;
  logic r_flag_nan;

  always_ff @(posedge clk) begin
    if (rst || flags_clr) begin
      r_nan_res      <= 1'b0;
      r_flag_invalid <= 1'b0;
      r_flag_nan     <= 1'b0;
    end else begin
      // A NaN pair is always special, so the CHECK-time value holds through RESP.
      if (r_state == ST_CHECK) r_nan_res <= |w_nan;
      if ((r_state == ST_RESP) && bus.out_ready) begin
        if (r_out_invalid) r_flag_invalid <= 1'b1;
        if (r_nan_res)     r_flag_nan     <= 1'b1;
      end
    end
  end

  assign flag_invalid = r_flag_invalid;
  assign flag_nan     = r_flag_nan;
`endif
endmodule

// File: tb/tb_fp_mul_scheduler.sv
module tb_fp_mul_scheduler;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_mul_scheduler_if #(.EXP_WIDTH(8), .MANT_WIDTH(23)) bus ();

`ifdef FP_MUL_SCHED_FLAGS_EN
  logic flags_clr = 1'b0;
  logic flag_invalid;
  logic flag_nan;
`endif

  fp_mul_scheduler #(.EXP_WIDTH(8), .MANT_WIDTH(23), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
`ifdef FP_MUL_SCHED_FLAGS_EN
    .flags_clr(flags_clr),
    .flag_invalid(flag_invalid),
    .flag_nan(flag_nan),
`endif
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] mres;   // value the fake multiplier returns
    int          dly;    // mul_done cycles after mul_start, 0 = never
    logic        sp;
    logic [31:0] res;
    logic        inv;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_op(input int idx, input vec_t v);
    int s;
    int vcyc;
    int starts;
    int exp_lat;
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.op_a = v.a; bus.op_b = v.b; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("mul_a", bus.mul_a, v.a);
    chk("mul_b", bus.mul_b, v.b);
    s = -1; vcyc = -1; starts = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.mul_start) begin
        starts++;
        if (s < 0) s = c;
      end
      bus.mul_result = v.mres;
      bus.mul_done   = (s > 0) && (v.dly > 0) && (c == s + v.dly);
      if (bus.out_valid) begin
        vcyc = c;
        break;
      end
      tick();
    end
    bus.mul_done = 1'b0;
    exp_lat = v.sp ? 2 : ((v.dly > 0) ? 2 + v.dly : 2 + TO);
    chk("latency", 32'(vcyc), 32'(exp_lat));
    chk("start_pulses", 32'(starts), v.sp ? 32'd0 : 32'd1);
    chk("out_result", bus.out_result, v.res);
    chk("out_special", 32'(bus.out_special), 32'(v.sp));
    chk("out_invalid", 32'(bus.out_invalid), 32'(v.inv));
    $display("op %0d: a=%08h b=%08h -> res=%08h sp=%0b inv=%0b lat=%0d",
             idx, v.a, v.b, bus.out_result, bus.out_special, bus.out_invalid, vcyc);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("post_hs_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h40000000, 32'h40000000, 3, 1'b0, 32'h40000000, 1'b0};
    vecs[1]  = '{32'h7F800000, 32'h80000000, 32'h0,        0, 1'b1, 32'h7FC00000, 1'b1};
    vecs[2]  = '{32'hFF800000, 32'h3F800000, 32'h0,        0, 1'b1, 32'hFF800000, 1'b0};
    vecs[3]  = '{32'h7FC00001, 32'h7F800000, 32'h0,        0, 1'b1, 32'h7FC00000, 1'b0};
    vecs[4]  = '{32'h00000000, 32'h80000000, 32'h0,        0, 1'b1, 32'h80000000, 1'b0};
    vecs[5]  = '{32'h00000001, 32'h3F800000, 32'h12345678, 1, 1'b0, 32'h12345678, 1'b0};
    vecs[6]  = '{32'h80000000, 32'hFF800000, 32'h0,        0, 1'b1, 32'h7FC00000, 1'b1};
    vecs[7]  = '{32'h00000000, 32'hFFFFFFFF, 32'h0,        0, 1'b1, 32'h7FC00000, 1'b0};
    vecs[8]  = '{32'hFF800000, 32'hC0000000, 32'h0,        0, 1'b1, 32'h7F800000, 1'b0};
    vecs[9]  = '{32'h3F800000, 32'h3F800000, 32'hDEADBEEF, 0, 1'b0, 32'h7FC00000, 1'b1};
    vecs[10] = '{32'h3F800000, 32'h3F800000, 32'hCAFEF00D, TO, 1'b0, 32'hCAFEF00D, 1'b0};

    bus.in_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.mul_done = 1'b0; bus.mul_result = '0; bus.out_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mul_start", 32'(bus.mul_start), 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_out_special", 32'(bus.out_special), 32'd0);
    chk("rst_out_invalid", 32'(bus.out_invalid), 32'd0);
    chk("rst_mul_a", bus.mul_a, 32'd0);
    chk("rst_mul_b", bus.mul_b, 32'd0);
`ifdef FP_MUL_SCHED_FLAGS_EN
    chk("rst_flag_invalid", 32'(flag_invalid), 32'd0);
`endif
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_op(i, vecs[i]);

`ifdef FP_MUL_SCHED_FLAGS_EN
    chk("flag_invalid_set", 32'(flag_invalid), 32'd1);
    chk("flag_nan_set", 32'(flag_nan), 32'd1);
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    chk("flag_invalid_clr", 32'(flag_invalid), 32'd0);
    chk("flag_nan_clr", 32'(flag_nan), 32'd0);
`endif

    // Back-pressure in RESP with in_valid held high
    bus.op_a = 32'hFF800000; bus.op_b = 32'h3F800000; bus.in_valid = 1'b1;
    tick();
    bus.op_a = 32'h40400000; bus.op_b = 32'h40400000;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_result", bus.out_result, 32'hFF800000);
      chk("stall_special", 32'(bus.out_special), 32'd1);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_mul_a", bus.mul_a, 32'hFF800000);
      $display("stall cycle %0d: valid=%0b res=%08h in_ready=%0b",
               k, bus.out_valid, bus.out_result, bus.in_ready);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("stall_release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("stall_release_valid", 32'(bus.out_valid), 32'd0);

    // Reset while BUSY, then a stale mul_done
    bus.op_a = 32'h3F800000; bus.op_b = 32'h40000000; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_mul_a", bus.mul_a, 32'd0);
    bus.mul_result = 32'h11111111; bus.mul_done = 1'b1;
    tick();
    bus.mul_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stale_out_valid", 32'(bus.out_valid), 32'd0);
      chk("stale_in_ready", 32'(bus.in_ready), 32'd1);
      $display("stale cycle %0d: valid=%0b in_ready=%0b", k, bus.out_valid, bus.in_ready);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_mul_scheduler.md
FP_MUL_SCHEDULER -- requirements
Module: fp_mul_scheduler

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter MANT_WIDTH, default 23, mantissa field width; W = EXP_WIDTH+MANT_WIDTH+1.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum BUSY cycles waiting for mul_done.
REQ-004 SHALL have port: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: in_valid in 1, in_ready out 1 (operand-pair handshake); op_a in W, op_b in W ([sign][exp][mantissa]).
REQ-007 SHALL have ports: mul_start out 1 (one-cycle pulse); mul_a out W, mul_b out W (captured operands); mul_done in 1; mul_result in W (valid with mul_done).
REQ-008 SHALL have ports: out_valid out 1, out_ready in 1, out_result out W, out_special out 1 (fast-path result), out_invalid out 1 (invalid operation or timeout).

Function
REQ-009 SHALL implement FSM IDLE, CHECK, BUSY, RESP; in_ready = 1 only in IDLE.
REQ-010 IDLE: on in_valid&in_ready, SHALL register op_a/op_b into mul_a/mul_b and go to CHECK; no acceptance in any other state.
REQ-011 CHECK SHALL classify each operand: zero (exp=0, mant=0), denormal (exp=0, mant!=0), infinity (exp all-ones, mant=0), NaN (exp all-ones, mant!=0), else normal.
REQ-012 Special priority SHALL be: any NaN > inf*0 > any infinity > any zero; sign_x = sign_a XOR sign_b.
REQ-013 NaN operand: result = canonical qNaN (sign 0, exp all-ones, mantissa MSB 1, rest 0), out_invalid=0.
REQ-014 inf*0 (either order): result = canonical qNaN, out_invalid=1.
REQ-015 Infinity otherwise: result = {sign_x, all-ones, 0}; zero otherwise: result = {sign_x, 0, 0}.
REQ-016 Special case SHALL go CHECK->RESP with out_special=1, without pulsing mul_start.
REQ-017 Non-special (normal/denormal combos) SHALL assert mul_start for exactly the CHECK cycle and go to BUSY; out_special=0.
REQ-018 BUSY: on mul_done SHALL capture mul_result into out_result, out_invalid=0, go to RESP; mul_done outside BUSY SHALL be ignored.
REQ-019 BUSY cycle counter SHALL clear on entry; if count reaches TIMEOUT-1 with no mul_done, SHALL go RESP with canonical qNaN, out_invalid=1; mul_done in that same cycle wins.
REQ-020 RESP: out_valid=1, out_result/out_special/out_invalid stable until out_valid&out_ready, then IDLE.
REQ-021 Latency from accept edge: special result out_valid 2 cycles later; normal result out_valid 1 cycle after the mul_done cycle.
REQ-022 Throughput SHALL be one operation in flight; no input accepted before RESP completes.

Reset
REQ-023 rst SHALL force IDLE, in_ready=1 next cycle, out_valid=0, mul_start=0, out_result=0, out_special=0, out_invalid=0, mul_a=mul_b=0, counter=0.
REQ-024 rst in any state (incl. BUSY mid-operation) SHALL abandon the operation; a later stale mul_done SHALL be ignored.

Configuration
REQ-025 Macro FP_MUL_SCHED_FLAGS_EN SHALL, when defined, add ports flags_clr in 1, flag_invalid out 1, flag_nan out 1: sticky flags set on each RESP handshake with out_invalid=1 or NaN-operand result, cleared by rst or flags_clr (clear wins over same-cycle set).
REQ-026 Without FP_MUL_SCHED_FLAGS_EN those ports and registers SHALL not exist; all other behaviour identical.

Verification
REQ-027 op_a=0x3F800000, op_b=0x40000000, mul_done 3 cycles after mul_start with 0x40000000 -> single mul_start pulse, out_result=0x40000000, out_special=0, out_invalid=0.
REQ-028 op_a=0x7F800000, op_b=0x80000000 -> no mul_start, out_valid 2 cycles after accept, out_result=0x7FC00000, out_special=1, out_invalid=1.
REQ-029 op_a=0xFF800000, op_b=0x3F800000 -> out_result=0xFF800000; op_a=0x7FC00001, op_b=0x7F800000 -> 0x7FC00000, out_invalid=0.
REQ-030 Normal pair, mul_done never asserted, TIMEOUT=8 -> out_valid after 8 BUSY cycles, out_result=0x7FC00000, out_invalid=1.
REQ-031 out_ready held 0 for 5 cycles in RESP, in_valid held 1 -> outputs stable, in_ready=0, no second accept until handshake.
REQ-032 rst asserted in BUSY, then mul_done pulsed in IDLE -> out_valid stays 0, in_ready=1; with FP_MUL_SCHED_FLAGS_EN, flag_invalid set after REQ-028 case and cleared by flags_clr.
